// File: rtl/password_update.sv
// Credential-enrollment FSM: a new password is keyed twice and, if both
// entries agree, written to the credential store at the logged-in user's ID.
module password_update #(
   parameter int unsigned DIGITS = 4,
   parameter int unsigned ID_W   = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [3:0]            PassSwitches,
   input  logic                  PassBtn,
   input  logic [1:0]            mode,
   input  logic                  timeout,
   input  logic                  LoggedIn,
   input  logic [ID_W-1:0]       MatchedID,
   output logic                  WriteEn,
   output logic [ID_W-1:0]       WriteAddr,
   output logic [4*DIGITS-1:0]   WriteData,
   output logic                  UpdateDone,
   output logic                  UpdateError,
   output logic [4:0]            letterLEDs
);

   localparam int unsigned CNT_W = 3;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

   typedef enum logic [3:0] {
      IDLE, ENTER, CONFIRM, WRITE, FAIL, OK, ERR, HOLD_OK, HOLD_ERR
   } state_t;

   state_t              state, state_n;
   logic [CNT_W-1:0]    cnt, cnt_n;
   logic [4*DIGITS-1:0] npw, npw_n;
   logic                mism, mism_n;
   logic [ID_W-1:0]     id, id_n;
   logic                abort, dig_miss, hit;

   logic                we_n, done_n, err_n;
   logic [ID_W-1:0]     addr_n;
   logic [4*DIGITS-1:0] data_n;
   logic [4:0]          leds_n;

   function automatic logic [3:0] therm(input logic [CNT_W-1:0] c);
      logic [3:0] t;
      for (int unsigned i = 0; i < 4; i++) t[i] = (CNT_W'(i) < c);
      return t;
   endfunction

   assign abort = timeout | ~LoggedIn | (mode != 2'b11);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         cnt         <= '0;
         npw         <= '0;
         mism        <= 1'b0;
         id          <= '0;
         WriteEn     <= 1'b0;
         WriteAddr   <= '0;
         WriteData   <= '0;
         UpdateDone  <= 1'b0;
         UpdateError <= 1'b0;
         letterLEDs  <= '0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         npw         <= npw_n;
         mism        <= mism_n;
         id          <= id_n;
         WriteEn     <= we_n;
         WriteAddr   <= addr_n;
         WriteData   <= data_n;
         UpdateDone  <= done_n;
         UpdateError <= err_n;
         letterLEDs  <= leds_n;
      end
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      npw_n    = npw;
      mism_n   = mism;
      id_n     = id;
      dig_miss = 1'b0;
      hit      = mism;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (cnt == CNT_W'(DIGITS - 1 - i) && npw[i*4 +: 4] != PassSwitches)
            dig_miss = 1'b1;
      end

      case (state)
         IDLE: begin
            if (LoggedIn && mode == 2'b11) begin
               id_n    = MatchedID;
               cnt_n   = '0;
               npw_n   = '0;
               mism_n  = 1'b0;
               state_n = ENTER;
            end
         end
         ENTER: begin
            if (abort) begin
               state_n = ERR;
            end else if (PassBtn) begin
               for (int unsigned i = 0; i < DIGITS; i++) begin
                  if (cnt == CNT_W'(DIGITS - 1 - i)) npw_n[i*4 +: 4] = PassSwitches;
               end
               if (cnt == LAST) begin
                  cnt_n   = '0;
                  state_n = CONFIRM;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
         end
         CONFIRM: begin
            if (abort) begin
               state_n = ERR;
            end else if (PassBtn) begin
               hit    = mism | dig_miss;
               mism_n = hit;
               if (cnt == LAST) begin
                  cnt_n   = '0;
                  // failure detours through FAIL so UpdateError lines up with UpdateDone
                  state_n = hit ? FAIL : WRITE;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
         end
         WRITE:   state_n = OK;
         FAIL:    state_n = ERR;
         OK:      state_n = HOLD_OK;
         ERR:     state_n = HOLD_ERR;
         HOLD_OK, HOLD_ERR: begin
            if (!LoggedIn || mode != 2'b11) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      // outputs are registered from the next state so they track the state exactly
      we_n   = (state_n == WRITE);
      addr_n = we_n ? id_n : '0;
      data_n = we_n ? npw_n : '0;
      done_n = (state_n == OK);
      err_n  = (state_n == ERR);
      case (state_n)
         ENTER:    leds_n = {1'b0, therm(cnt_n)};
         CONFIRM:  leds_n = {1'b1, therm(cnt_n)};
         HOLD_OK:  leds_n = 5'b11111;
         HOLD_ERR: leds_n = 5'b10101;
         default:  leds_n = '0;
      endcase
   end

endmodule
